// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared definitions for the PRBS word arbiter: the reset/substitute seed,
//   the Galois feedback mask, the controller state type and the single-step
//   generator function used by the state register.
package lfsr_pkg;

  localparam logic [15:0] SEED_RST  = 16'hA2C1;
  localparam logic [15:0] POLY_MASK = 16'h8006;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One Galois step: shift right, fold the mask in when the bit leaving
  // position 0 is set.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                            input logic [15:0] mask);
    return (s >> 1) ^ (s[0] ? mask : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_word_arbiter_core.sv
// lfsr_galois_step_core
//   16-bit Galois PRBS state register.
//   Ports:
//     clk, nrst  clock, asynchronous active-low reset (state -> SEED_RST)
//     load       load 'seed' into the state (takes priority over en)
//     seed       value to load
//     en         advance the generator by one step
//     out_bit    current s[0], i.e. the bit produced by the next step
module lfsr_galois_step_core #(
  parameter logic [15:0] SEED_RST  = 16'hA2C1,
  parameter logic [15:0] POLY_MASK = 16'h8006
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic        out_bit
);
  import lfsr_pkg::*;

  logic [15:0] s;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s <= SEED_RST;
    end else if (load) begin
      s <= seed;
    end else if (en) begin
      s <= lfsr_step(s, POLY_MASK);
    end
  end

  assign out_bit = s[0];

endmodule

// File: rtl/lfsr_word_arbiter.sv
// lfsr_word_arbiter
//   Shares one 16-bit Galois PRBS generator among NUM_REQ requesters. A
//   round-robin winner is captured from IDLE, the generator is stepped 16
//   times to assemble a word LSB first, then the word is presented for one
//   cycle together with a one-hot grant.
//   Ports:
//     clk, nrst      clock, asynchronous active-low reset
//     req            per-requester request level, held until its gnt
//     gnt            one-hot, one-cycle grant strobe qualifying 'word'
//     word           assembled PRBS word, zero whenever gnt is zero
//     seed_we, seed  generator reseed (honoured only in IDLE); zero seed
//                    substitutes SEED_RST and sets zero_seed_err
//     busy           high in SHIFT and DONE
//     zero_seed_err  sticky zero-seed flag, cleared only by reset
//     word_cnt       number of words delivered, wrapping
module lfsr_word_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [15:0] SEED_RST  = lfsr_pkg::SEED_RST,
  parameter logic [15:0] POLY_MASK = lfsr_pkg::POLY_MASK
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        word,
  input  logic               seed_we,
  input  logic [15:0]        seed,
  output logic               busy,
  output logic               zero_seed_err,
  output logic [15:0]        word_cnt
);
  import lfsr_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [3:0]         bit_cnt;
  logic [15:0]        word_sr;

  logic               gen_bit;
  logic               gen_load;
  logic               gen_en;
  logic [15:0]        gen_seed;

  // Round-robin search: rotate the request vector so the RR pointer lands
  // at bit 0, take the lowest set bit, then rotate the offset back.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     pick_ofs;
  logic [PTR_W:0]       pick_sum;
  logic [PTR_W-1:0]     pick;
  logic                 any_req;
  logic [PTR_W-1:0]     rr_next;

  assign req_dbl = {req, req} >> rr_ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];
  assign any_req = |req;

  always_comb begin
    pick_ofs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_ofs = PTR_W'(i);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_ofs};
    if (pick_sum >= (PTR_W+1)'(NUM_REQ)) begin
      pick = PTR_W'(pick_sum - (PTR_W+1)'(NUM_REQ));
    end else begin
      pick = PTR_W'(pick_sum);
    end
  end

  assign rr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);

  // Reseeding is only accepted while idle; a zero seed would lock the
  // generator at zero, so it is replaced by the reset seed.
  assign gen_load = (state == IDLE) && seed_we;
  assign gen_seed = (seed == 16'h0000) ? SEED_RST : seed;
  assign gen_en   = (state == SHIFT);

  lfsr_galois_step_core #(
    .SEED_RST  (SEED_RST),
    .POLY_MASK (POLY_MASK)
  ) u_core (
    .clk     (clk),
    .nrst    (nrst),
    .load    (gen_load),
    .seed    (gen_seed),
    .en      (gen_en),
    .out_bit (gen_bit)
  );

  // Word assembly: the bit about to leave the generator goes into position
  // bit_cnt. Every bit is rewritten before the word is presented, so this
  // register needs no reset.
  always_ff @(posedge clk) begin
    if (state == SHIFT) begin
      word_sr[bit_cnt] <= gen_bit;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      winner        <= '0;
      bit_cnt       <= '0;
      gnt           <= '0;
      word          <= '0;
      zero_seed_err <= 1'b0;
      word_cnt      <= '0;
    end else begin
      gnt  <= '0;
      word <= '0;
      case (state)
        IDLE: begin
          if (seed_we) begin
            if (seed == 16'h0000) zero_seed_err <= 1'b1;
          end else if (any_req) begin
            winner  <= pick;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          gnt      <= NUM_REQ'(1) << winner;
          word     <= word_sr;
          word_cnt <= word_cnt + 16'd1;
          rr_ptr   <= rr_next;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// tb_lfsr_word_arbiter
//   Self-checking bench for lfsr_word_arbiter. A transaction-level model
//   (whole word computed at capture, grant scheduled 17 edges later) is
//   compared against every DUT output on every falling edge, and directed
//   scenarios add literal expectations.
module tb_lfsr_word_arbiter;
  localparam int          N     = 4;
  localparam logic [15:0] SEED0 = 16'hA2C1;
  localparam logic [15:0] POLY  = 16'h8006;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [N-1:0]   req = '0;
  logic           seed_we = 1'b0;
  logic [15:0]    seed = '0;
  logic [N-1:0]   gnt;
  logic [15:0]    word;
  logic           busy;
  logic           zero_seed_err;
  logic [15:0]    word_cnt;

  lfsr_word_arbiter #(
    .NUM_REQ   (N),
    .SEED_RST  (SEED0),
    .POLY_MASK (POLY)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .req           (req),
    .gnt           (gnt),
    .word          (word),
    .seed_we       (seed_we),
    .seed          (seed),
    .busy          (busy),
    .zero_seed_err (zero_seed_err),
    .word_cnt      (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_req = 1'b0;

  // Model state
  logic [15:0]  m_prng   = SEED0;
  int           m_rr     = 0;
  bit           m_err    = 1'b0;
  logic [15:0]  m_cnt    = '0;
  bit           m_active = 1'b0;
  int           m_age    = 0;
  int           m_winner = 0;
  logic [15:0]  m_word   = '0;
  logic [N-1:0] e_gnt    = '0;
  logic [15:0]  e_word   = '0;

  function automatic logic [15:0] prbs_word(input logic [15:0] s0,
                                            output logic [15:0] s_next);
    logic [15:0] s;
    logic [15:0] w;
    s = s0;
    w = '0;
    for (int b = 0; b < 16; b++) begin
      w[b] = s[0];
      s = (s >> 1) ^ (s[0] ? POLY : 16'h0000);
    end
    s_next = s;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prng   = SEED0;
    m_rr     = 0;
    m_err    = 1'b0;
    m_cnt    = '0;
    m_active = 1'b0;
    m_age    = 0;
    e_gnt    = '0;
    e_word   = '0;
  endtask

  task automatic model_edge();
    logic [15:0] nxt;
    if (!nrst) begin
      model_reset();
      return;
    end
    e_gnt  = '0;
    e_word = '0;
    if (m_active) begin
      m_age++;
      if (m_age == 17) begin
        e_gnt    = N'(1) << m_winner;
        e_word   = m_word;
        m_cnt    = m_cnt + 16'd1;
        m_rr     = (m_winner + 1) % N;
        m_active = 1'b0;
      end
    end else if (seed_we) begin
      if (seed == 16'h0000) begin
        m_prng = SEED0;
        m_err  = 1'b1;
      end else begin
        m_prng = seed;
      end
    end else if (req != '0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[(m_rr + i) % N]) m_winner = (m_rr + i) % N;
      end
      m_word   = prbs_word(m_prng, nxt);
      m_prng   = nxt;
      m_active = 1'b1;
      m_age    = 0;
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("word", 32'(word), 32'(e_word));
    check("busy", 32'(busy), 32'(m_active));
    check("zero_seed_err", 32'(zero_seed_err), 32'(m_err));
    check("word_cnt", 32'(word_cnt), 32'(m_cnt));
  endtask

  // One clock: update the model at the rising edge, compare at the falling
  // edge, then let granted requesters drop their request.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (!hold_req) req = req & ~gnt;
  endtask

  task automatic do_reset();
    nrst    = 1'b0;
    req     = '0;
    seed_we = 1'b0;
    model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_word", 32'(word), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cnt", 32'(word_cnt), 32'h0);
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_gnt(input int already, output int lat,
                          output logic [N-1:0] g, output logic [15:0] w);
    lat = already;
    g   = '0;
    w   = '0;
    while (lat < 60) begin
      tick();
      lat++;
      if (gnt != '0) begin
        g = gnt;
        w = word;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL gnt_timeout: no grant within %0d cycles at t=%0t", lat, $time);
  endtask

  initial begin
    int           lat;
    logic [N-1:0] g;
    logic [15:0]  w;
    logic [15:0]  first_word;
    logic [15:0]  dummy;
    logic [N-1:0] order [5];

    first_word = prbs_word(SEED0, dummy);
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset values
    tick();
    tick();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(zero_seed_err), 32'h0);
    check("reset_cnt", 32'(word_cnt), 32'h0);
    nrst = 1'b1;
    tick();

    // Single request with the reset seed: 17 edges from sample to grant
    req = 4'b0001;
    tick();
    check("busy_in_service", 32'(busy), 32'h1);
    wait_gnt(1, lat, g, w);
    check("latency_ticks", 32'(lat), 32'd18);
    check("first_gnt", 32'(g), 32'h1);
    check("first_word", 32'(w), 32'(first_word));
    check("first_cnt", 32'(word_cnt), 32'h1);

    // Reseed with 1, serve requester 2
    seed_we = 1'b1;
    seed    = 16'h0001;
    tick();
    seed_we = 1'b0;
    req     = 4'b0100;
    wait_gnt(0, lat, g, w);
    check("seed1_gnt", 32'(g), 32'h4);
    check("seed1_word", 32'(w), 32'h4E9D);
    check("seed1_model_state", 32'(m_prng), 32'h4E9E);

    // All four requesting continuously: rotation 0,1,2,3,0 every 18 cycles
    do_reset();
    hold_req = 1'b1;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(0, lat, g, w);
      check("rr_order", 32'(g), 32'(order[k]));
      check("rr_spacing", 32'(lat), 32'd18);
    end
    hold_req = 1'b0;
    req      = '0;
    tick();

    // seed_we during SHIFT is ignored, even with a zero seed
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    seed_we = 1'b1;
    seed    = 16'h0000;
    tick();
    seed_we = 1'b0;
    wait_gnt(0, lat, g, w);
    check("shift_seed_word", 32'(w), 32'(first_word));
    check("shift_seed_err", 32'(zero_seed_err), 32'h0);

    // Zero seed in IDLE substitutes the reset seed and sets the sticky flag
    do_reset();
    seed_we = 1'b1;
    seed    = 16'h0000;
    tick();
    seed_we = 1'b0;
    check("zero_seed_err_set", 32'(zero_seed_err), 32'h1);
    req = 4'b0001;
    wait_gnt(0, lat, g, w);
    check("zero_seed_word", 32'(w), 32'(first_word));
    tick();
    check("zero_seed_err_sticky", 32'(zero_seed_err), 32'h1);

    // Reset during the 8th SHIFT cycle
    do_reset();
    req = 4'b0001;
    wait_gnt(0, lat, g, w);
    req = 4'b0001;
    tick();
    for (int k = 0; k < 8; k++) tick();
    do_reset();
    req = 4'b1010;
    wait_gnt(0, lat, g, w);
    check("post_reset_gnt", 32'(g), 32'h2);
    check("post_reset_word", 32'(w), 32'(first_word));

    // word_cnt wrap
    force dut.word_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.word_cnt;
    tick();
    req = 4'b0100;
    wait_gnt(0, lat, g, w);
    check("cnt_wrap", 32'(word_cnt), 32'h0);

    // Randomized traffic, reseeds and occasional resets
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      seed_we = ($urandom_range(0, 15) == 0);
      seed    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      req     = req | (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 300) == 0) begin
        nrst = 1'b0;
        model_reset();
      end else begin
        nrst = 1'b1;
      end
      tick();
    end
    nrst    = 1'b1;
    seed_we = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
